memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Shares one external memory port between three clients: instruction fetch (read),
//  memory_stage load (read) and memory_stage store (write). Each client sees the
//  activate/done interface that the pipeline stages already use. Requests are
//  serialised through a registered FSM, with data traffic prioritised and a
//  starvation bound for instruction fetch.
// PARAMETERS
//  ADDR_WIDTH     32  address width (localparam)
//  DATA_WIDTH     32  data width (localparam); DATA_INDEXING_WIDTH = $clog2(DATA_WIDTH/8)
//  STARVE_LIMIT   4   consecutive data grants allowed while ifetch waits; then ifetch wins
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    reset, asynchronous, active-high
//  if_fetch_addr       in   32   instruction fetch address
//  if_fetch_activate   in   1    instruction fetch request (level)
//  if_fetched_data     out  32   instruction word, valid while if_fetch_done
//  if_fetch_done       out  1    instruction fetch complete (level, see BEHAVIOUR)
//  ds_fetch_addr       in   32   load address from memory_stage
//  ds_fetch_activate   in   1    load request (level)
//  ds_fetched_data     out  32   raw load word; memory_stage does the extension
//  ds_fetch_done       out  1    load complete
//  ds_write_addr       in   32   store address
//  ds_write_data       in   32   store data, LSB-aligned
//  ds_bytes_to_write   in   3    1, 2 or 4 bytes
//  ds_write_activate   in   1    store request (level)
//  ds_write_done       out  1    store complete
//  mem_req             out  1    external request, held until mem_ack
//  mem_write           out  1    1 = write, 0 = read
//  mem_addr            out  32   external address
//  mem_wdata           out  32   external write data
//  mem_bytes           out  3    byte count (reads always 4)
//  mem_rdata           in   32   read data, sampled on mem_ack
//  mem_ack             in   1    one-cycle completion; ignored unless mem_req=1
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE. mem_req, mem_write and all *_done outputs = 0.
//   mem_bytes = 0, starve_cnt = 0, completion flags cleared. Data regs reset to 0.
//  FSM states and transitions:
//   IDLE   -> select a client and latch its fields into the mem_* registers.
//             mem_req rises the next cycle, so an issue costs 1 cycle.
//   BUSY   -> hold mem_* stable. On mem_ack: latch mem_rdata into the owner's data
//             register, set the owner's done flag and return to IDLE.
//  Selection among live clients (live = activate=1 and done flag clear):
//   ds_write > ds_fetch > if_fetch.
//   Exception: if starve_cnt == STARVE_LIMIT and ifetch is live, ifetch wins.
//  starve_cnt: +1 on each data grant while ifetch is live, saturating.
//   Cleared on an ifetch grant or when if_fetch_activate = 0.
//  done flags are levels. A flag is held, with its data stable, while activate stays 1
//   and the request fields (addr, plus data and bytes for writes) equal the values
//   latched at grant.
//  A flag clears the cycle after activate drops or any latched field changes.
//   If activate is still 1 at that point, a new request goes live immediately.
//  Identical back-to-back requests (same fields, activate never dropped) therefore
//   merge into one transaction. This is accepted; the MMIO caveat is documented.
//  Activate dropped while that client is in BUSY: finish the transaction, discard
//   the result and leave the done flag clear.
//  ds_write_activate and ds_fetch_activate both 1: write is served. The load is then
//   served afterwards.
//  mem_ack in the same cycle as an activate edge: the completion takes effect first.
//   The new request is evaluated in the following IDLE cycle.
//  Minimum round trip: activate at cycle 0 -> mem_req at cycle 1 -> mem_ack at
//   cycle 1 or later -> done at cycle ack+1.
// STRUCTURE
//  Shared package mem_pkg: typedef enum {IDLE, BUSY} arb_state_t.
//   Also in mem_pkg: typedef enum {OWN_IF, OWN_DR, OWN_DW} arb_owner_t.
//   Also in mem_pkg: byte-count constants BYTES_B=1, BYTES_H=2, BYTES_W=4.
//  One natural sub-module, mem_client_slot, instantiated three times. It holds
//   the latched fields, the done flag, the result register and the field-compare logic.
//  The arbiter top holds the FSM, the priority/starvation logic and the mem_* registers.
// TESTING
//  1 Reset mid-BUSY: assert rst while mem_req=1 -> mem_req=0 and all done=0 at once;
//    after release, an ack from the old transaction is ignored.
//  2 Single load, addr 0x100: ack after 3 cycles with 0xDEADBEEF -> ds_fetch_done=1,
//    ds_fetched_data=0xDEADBEEF, held while activate=1 and addr unchanged.
//  3 Store 0x200, data 0x0000_00AB, bytes 1 -> mem_write=1, mem_bytes=1.
//    ds_write_done stays until addr changes to 0x204; a second write is then issued.
//  4 Ifetch and load both requested in the same cycle -> load is granted first;
//    ifetch is granted on the next IDLE.
//  5 Continuous data requests with ifetch live, STARVE_LIMIT=4 -> exactly 4 data
//    grants, then ifetch is granted, then starve_cnt=0.
//  6 Ifetch activate dropped while BUSY -> transaction completes,
//    if_fetch_done stays 0, the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and its client slots.
package mem_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int DATA_WIDTH          = 32;
    localparam int DATA_INDEXING_WIDTH = $clog2(DATA_WIDTH / 8);

    // Byte counts carried on mem_bytes; reads always use BYTES_W.
    localparam logic [2:0] BYTES_B = 3'd1;
    localparam logic [2:0] BYTES_H = 3'd2;
    localparam logic [2:0] BYTES_W = 3'd4;

    typedef logic [DATA_INDEXING_WIDTH-1:0] byte_index_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_IF,
        OWN_DR,
        OWN_DW
    } arb_owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the three client activate/done ports and the external memory port.
interface memory_arbiter_if;
    import mem_pkg::*;

    logic [ADDR_WIDTH-1:0] if_fetch_addr;
    logic                  if_fetch_activate;
    logic [DATA_WIDTH-1:0] if_fetched_data;
    logic                  if_fetch_done;

    logic [ADDR_WIDTH-1:0] ds_fetch_addr;
    logic                  ds_fetch_activate;
    logic [DATA_WIDTH-1:0] ds_fetched_data;
    logic                  ds_fetch_done;

    logic [ADDR_WIDTH-1:0] ds_write_addr;
    logic [DATA_WIDTH-1:0] ds_write_data;
    logic [2:0]            ds_bytes_to_write;
    logic                  ds_write_activate;
    logic                  ds_write_done;

    logic                  mem_req;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_bytes;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    // Arbiter side: serves the clients, drives the memory port.
    modport slave (
        input  if_fetch_addr, if_fetch_activate,
        output if_fetched_data, if_fetch_done,
        input  ds_fetch_addr, ds_fetch_activate,
        output ds_fetched_data, ds_fetch_done,
        input  ds_write_addr, ds_write_data, ds_bytes_to_write, ds_write_activate,
        output ds_write_done,
        output mem_req, mem_write, mem_addr, mem_wdata, mem_bytes,
        input  mem_rdata, mem_ack
    );

    // Environment side: pipeline clients plus the external memory.
    modport master (
        output if_fetch_addr, if_fetch_activate,
        input  if_fetched_data, if_fetch_done,
        output ds_fetch_addr, ds_fetch_activate,
        input  ds_fetched_data, ds_fetch_done,
        output ds_write_addr, ds_write_data, ds_bytes_to_write, ds_write_activate,
        input  ds_write_done,
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_bytes,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_client_slot.sv
// One client of the arbiter: latched request fields, level done flag and result.
module mem_client_slot
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  activate,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            byte_cnt,
    input  logic                  grant,
    input  logic                  complete,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  live,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [2:0]            lat_bytes;
    logic                  pending;
    logic                  abandon;
    logic                  fields_match;

    assign fields_match = (addr == lat_addr) && (wdata == lat_wdata) && (byte_cnt == lat_bytes);
    assign live         = activate && !done && !pending;

    // Latch fields at grant, track abandonment while owned, and keep the done level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_bytes <= '0;
            pending   <= 1'b0;
            abandon   <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            if (grant) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_bytes <= byte_cnt;
                pending   <= 1'b1;
                abandon   <= 1'b0;
            end else if (complete) begin
                pending <= 1'b0;
                // A request withdrawn or altered mid-flight completes silently.
                if (!abandon && activate && fields_match) begin
                    done   <= 1'b1;
                    result <= rdata;
                end
            end else if (pending && (!activate || !fields_match)) begin
                abandon <= 1'b1;
            end
            if (done && (!activate || !fields_match)) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises ifetch, load and store clients onto one external memory port.
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    memory_arbiter_if.slave   bus
);

    localparam int                CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]     LIMIT = CW'(STARVE_LIMIT);

    arb_state_t            state, next_state;
    arb_owner_t            owner, sel_owner;
    logic [CW-1:0]         starve_cnt;
    logic                  grant_if, grant_dr, grant_dw, grant_any;
    logic                  if_live, dr_live, dw_live;
    logic                  complete;
    logic [DATA_WIDTH-1:0] dw_result_unused;

    assign grant_any = grant_if || grant_dr || grant_dw;
    assign complete  = (state == BUSY) && bus.mem_ack;

    mem_client_slot u_if_slot (
        .clk(clk), .rst(rst),
        .activate(bus.if_fetch_activate), .addr(bus.if_fetch_addr),
        .wdata('0), .byte_cnt(BYTES_W),
        .grant(grant_if), .complete(complete && owner == OWN_IF), .rdata(bus.mem_rdata),
        .live(if_live), .done(bus.if_fetch_done), .result(bus.if_fetched_data)
    );

    mem_client_slot u_dr_slot (
        .clk(clk), .rst(rst),
        .activate(bus.ds_fetch_activate), .addr(bus.ds_fetch_addr),
        .wdata('0), .byte_cnt(BYTES_W),
        .grant(grant_dr), .complete(complete && owner == OWN_DR), .rdata(bus.mem_rdata),
        .live(dr_live), .done(bus.ds_fetch_done), .result(bus.ds_fetched_data)
    );

    mem_client_slot u_dw_slot (
        .clk(clk), .rst(rst),
        .activate(bus.ds_write_activate), .addr(bus.ds_write_addr),
        .wdata(bus.ds_write_data), .byte_cnt(bus.ds_bytes_to_write),
        .grant(grant_dw), .complete(complete && owner == OWN_DW), .rdata(bus.mem_rdata),
        .live(dw_live), .done(bus.ds_write_done), .result(dw_result_unused)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and client selection: starved ifetch, then write, load, ifetch.
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_dr   = 1'b0;
        grant_dw   = 1'b0;
        sel_owner  = OWN_IF;
        case (state)
            IDLE: begin
                if (if_live && starve_cnt == LIMIT) begin
                    grant_if  = 1'b1;
                    sel_owner = OWN_IF;
                end else if (dw_live) begin
                    grant_dw  = 1'b1;
                    sel_owner = OWN_DW;
                end else if (dr_live) begin
                    grant_dr  = 1'b1;
                    sel_owner = OWN_DR;
                end else if (if_live) begin
                    grant_if  = 1'b1;
                    sel_owner = OWN_IF;
                end
                if (grant_if || grant_dr || grant_dw) next_state = BUSY;
            end
            BUSY: begin
                if (bus.mem_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // External port registers: loaded at grant, held through BUSY, request dropped on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_bytes <= '0;
            owner         <= OWN_IF;
        end else if (grant_any) begin
            bus.mem_req <= 1'b1;
            owner       <= sel_owner;
            if (grant_dw) begin
                bus.mem_write <= 1'b1;
                bus.mem_addr  <= bus.ds_write_addr;
                bus.mem_wdata <= bus.ds_write_data;
                bus.mem_bytes <= bus.ds_bytes_to_write;
            end else begin
                bus.mem_write <= 1'b0;
                bus.mem_addr  <= grant_dr ? bus.ds_fetch_addr : bus.if_fetch_addr;
                bus.mem_wdata <= '0;
                bus.mem_bytes <= BYTES_W;
            end
        end else if (complete) begin
            bus.mem_req <= 1'b0;
        end
    end

    // Count data grants that bypass a waiting ifetch, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_fetch_activate || grant_if) begin
            starve_cnt <= '0;
        end else if ((grant_dw || grant_dr) && if_live && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
